// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared defaults, counter width and FSM encoding for the data-memory responder
package data_mem_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_BITS = 8;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/word_ram.sv
// word_ram: single-port synchronous RAM with one write enable and a registered, enabled read
module word_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_BITS];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
  // Read register only moves on an enabled read, so it doubles as the held load data.
  always_ff @(posedge clk) begin
    if (rst) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle word-addressed data memory with wait states and ready/busy handshake
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] writeData,
  input  logic              memRead,
  input  logic              memWrite,
  output logic [DATA_W-1:0] readDataMem,
  output logic              ready,
  output logic              busy,
  output logic              addrError
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, cur_addr;
  logic [DATA_W-1:0] wdata_q, cur_data, ram_rdata;
  logic wr_q, cur_wr, req, in_range, fire, ready_q, busy_q, err_q, zero_q;
  assign req = memRead | memWrite;
  // With zero wait states the access happens on the accepting edge, before the latches hold it.
  assign cur_addr = (state_q == IDLE) ? address : addr_q;
  assign cur_data = (state_q == IDLE) ? writeData : wdata_q;
  assign cur_wr = (state_q == IDLE) ? memWrite : wr_q;
  assign in_range = ~|cur_addr[31:ADDR_BITS];
  assign fire = !rst && (state_d == DONE);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
        cnt_d = CNT_W'(WAIT_CYCLES);
      end
      WAIT: begin
        state_d = (cnt_q <= CNT_W'(1)) ? DONE : WAIT;
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= (state_d == DONE);
      busy_q <= (state_d != IDLE);
      if (fire) err_q <= !in_range;
      if (fire && !cur_wr) zero_q <= !in_range;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      addr_q <= address;
      wdata_q <= writeData;
      wr_q <= memWrite;
    end
  end
  word_ram #(.DATA_W(DATA_W), .ADDR_BITS(ADDR_BITS)) u_ram (
    .clk(clk),
    .rst(rst),
    .we_i(fire && cur_wr && in_range),
    .re_i(fire && !cur_wr && in_range),
    .addr_i(cur_addr[ADDR_BITS-1:0]),
    .wdata_i(cur_data),
    .rdata_o(ram_rdata)
  );
  assign readDataMem = zero_q ? '0 : ram_rdata;
  assign ready = ready_q;
  assign busy = busy_q;
  assign addrError = err_q;
endmodule
